// File: rtl/bcd_calc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bcd_calc_ctrl_pkg
// Shared constants for the BCD calculator sequencer:
//   state_e   - sequencer states (encodings are visible on state_o)
//   OFF_CODE  - digit code that the seven-segment decoder renders as blank
//   BCD_MAX   - largest legal BCD digit
//   NDIG_REQ  - operand width in digits that the subtractor supports
// -----------------------------------------------------------------------------
package bcd_calc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_X = 2'd0,
    ST_LOAD_Y = 2'd1,
    ST_CALC   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] OFF_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam int         NDIG_REQ = 3;

  // Calculator-style entry: existing digits move one place left and the new
  // digit lands in the ones position. Layout is {huns, tens, ones}.
  function automatic logic [11:0] shift_in(input logic [11:0] v, input logic [3:0] d);
    return {v[7:0], d};
  endfunction

endpackage

// File: rtl/bcd_calc_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_calc_ctrl_if
// Bundles the keypad strobes, result handshake and display bus of the
// BCD calculator sequencer.
//   master : keypad/consumer side (drives strobes and res_ready)
//   slave  : the sequencer (drives display, result, err, state_o)
//
// Handshake: res_valid/res_ready. A result transfers on any rising clock edge
// where res_valid && res_ready. While res_valid is high and res_ready is low
// the producer keeps res_valid and res_* stable; res_valid never drops before
// the transfer except on clr_stb or reset, which discard the result.
// -----------------------------------------------------------------------------
interface bcd_calc_ctrl_if;
  logic [3:0] digit_in;
  logic       digit_stb;
  logic       enter_stb;
  logic       clr_stb;
  logic       res_ready;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;
  logic [3:0] disp_huns;
  logic       disp_neg;
  logic       res_valid;
  logic [3:0] res_ones;
  logic [3:0] res_tens;
  logic [3:0] res_huns;
  logic       res_neg;
  logic       err;
  logic [1:0] state_o;

  modport master (
    output digit_in, digit_stb, enter_stb, clr_stb, res_ready,
    input  disp_ones, disp_tens, disp_huns, disp_neg,
    input  res_valid, res_ones, res_tens, res_huns, res_neg, err, state_o
  );

  modport slave (
    input  digit_in, digit_stb, enter_stb, clr_stb, res_ready,
    output disp_ones, disp_tens, disp_huns, disp_neg,
    output res_valid, res_ones, res_tens, res_huns, res_neg, err, state_o
  );
endinterface

// File: rtl/bcd_calc_ctrl_subtractor.sv
// -----------------------------------------------------------------------------
// bcd_subtractor
// Combinational 3-digit BCD magnitude subtractor.
//   a, b  in  12  operands, {huns, tens, ones}
//   diff  out 12  |a - b| in BCD
//   sign  out 1   1 when a >= b
// Both a-b and b-a are formed with a digit-wise borrow chain; the final
// borrow of a-b selects which one is the magnitude.
// -----------------------------------------------------------------------------
module bcd_subtractor (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] diff,
  output logic        sign
);

  // Returns {borrow_out, difference}. A negative digit result wraps in 5 bits;
  // adding 10 back leaves the correct BCD digit in the low nibble.
  function automatic logic [12:0] bcd_sub(input logic [11:0] p, input logic [11:0] q);
    logic [4:0]  t;
    logic        brw;
    logic [11:0] d;
    brw = 1'b0;
    d   = '0;
    for (int i = 0; i < 3; i++) begin
      t   = {1'b0, p[i*4 +: 4]} - {1'b0, q[i*4 +: 4]} - {4'd0, brw};
      brw = t[4];
      if (brw) t = t + 5'd10;
      d[i*4 +: 4] = t[3:0];
    end
    return {brw, d};
  endfunction

  logic [12:0] a_minus_b;
  logic [12:0] b_minus_a;

  always_comb begin
    a_minus_b = bcd_sub(a, b);
    b_minus_a = bcd_sub(b, a);
    sign      = ~a_minus_b[12];
    diff      = sign ? a_minus_b[11:0] : b_minus_a[11:0];
  end

endmodule

// File: rtl/bcd_calc_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_calc_ctrl
// Sequencer for the 3-digit BCD subtractor: collects X then Y from keypad
// strobes, computes |X-Y| and sign, holds the result for a valid/ready
// consumer and drives a 3-digit display.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         bcd_calc_ctrl_if.slave: strobes, res_ready in; display,
//               result, err and state_o out
// Parameters:
//   BLANK_LZ  1 = leading-zero huns/tens shown as OFF_CODE (ones never blank)
//   NDIG      digits per operand; only 3 is supported
// Build option:
//   BCD_CALC_ACCUM_EN  when defined, an accepted result becomes the next X and
//                      the sequencer resumes in LOAD_Y (chained subtraction);
//                      a negative result instead clears X and sets err.
// Strobe priority: clr_stb > enter_stb > digit_stb; losers are dropped.
// -----------------------------------------------------------------------------
module bcd_calc_ctrl
  import bcd_calc_ctrl_pkg::*;
#(
  parameter int BLANK_LZ = 1,
  parameter int NDIG     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_calc_ctrl_if.slave  bus
);

  if (NDIG != NDIG_REQ) begin : g_ndig_check
    $error("bcd_calc_ctrl: NDIG must be 3");
  end

  state_e      state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] res_q, res_d;
  logic        res_neg_q, res_neg_d;
  logic        res_valid_q, res_valid_d;
  logic        err_q, err_d;

  logic [11:0] sub_diff;
  logic        sub_sign;

  bcd_subtractor u_sub (
    .a    (x_q),
    .b    (y_q),
    .diff (sub_diff),
    .sign (sub_sign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD_X;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      res_neg_q   <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      res_neg_q   <= res_neg_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_neg_d   = res_neg_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;

    if (bus.clr_stb) begin
      state_d     = ST_LOAD_X;
      x_d         = '0;
      y_d         = '0;
      cnt_d       = '0;
      res_d       = '0;
      res_neg_d   = 1'b0;
      res_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_X, ST_LOAD_Y: begin
          if (bus.enter_stb) begin
            if (state_q == ST_LOAD_X) begin
              state_d = ST_LOAD_Y;
              y_d     = '0;
              cnt_d   = '0;
            end else begin
              state_d = ST_CALC;
            end
          end else if (bus.digit_stb) begin
            // Over-long entry and non-BCD codes leave the operand untouched.
            if ((bus.digit_in > BCD_MAX) || (cnt_q == 2'(NDIG))) begin
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 2'd1;
              if (state_q == ST_LOAD_X) x_d = shift_in(x_q, bus.digit_in);
              else                      y_d = shift_in(y_q, bus.digit_in);
            end
          end
        end
        ST_CALC: begin
          res_d       = sub_diff;
          res_neg_d   = ~sub_sign;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
            y_d         = '0;
            cnt_d       = '0;
`ifdef BCD_CALC_ACCUM_EN
            state_d = ST_LOAD_Y;
            if (res_neg_q) begin
              x_d   = '0;
              err_d = 1'b1;
            end else begin
              x_d = res_q;
            end
`else
            state_d = ST_LOAD_X;
            x_d     = '0;
`endif
          end
        end
        default: state_d = ST_LOAD_X;
      endcase
    end
  end

  // Display: combinational mux of registered values with leading-zero blanking.
  logic [11:0] disp_src;

  always_comb begin
    case (state_q)
      ST_LOAD_X: disp_src = x_q;
      ST_DONE:   disp_src = res_q;
      default:   disp_src = y_q;
    endcase
    bus.disp_ones = disp_src[3:0];
    bus.disp_tens = disp_src[7:4];
    bus.disp_huns = disp_src[11:8];
    if (BLANK_LZ != 0) begin
      if (disp_src[11:8] == 4'd0) bus.disp_huns = OFF_CODE;
      if (disp_src[11:4] == 8'd0) bus.disp_tens = OFF_CODE;
    end
    bus.disp_neg = (state_q == ST_DONE) && res_neg_q;
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_ones  = res_q[3:0];
  assign bus.res_tens  = res_q[7:4];
  assign bus.res_huns  = res_q[11:8];
  assign bus.res_neg   = res_neg_q;
  assign bus.err       = err_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
module tb_bcd_calc_ctrl;

  localparam logic [1:0] S_LX = 2'd0, S_LY = 2'd1, S_CALC = 2'd2, S_DONE = 2'd3;
  localparam logic [11:0] DISP_ZERO = 12'hFF0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_calc_ctrl_if bus();

  bcd_calc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];   // scoreboard entries: {neg, huns, tens, ones}

  typedef struct {
    int x;
    int y;
    bit pre_ready;
    int exp_mag;
    bit exp_neg;
  } vec_t;
  vec_t vecs[8];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Display rule: huns blank when zero, tens blank when huns and tens zero.
  function automatic logic [11:0] disp_of(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    if (d[11:8] == 4'd0) r[11:8] = 4'hF;
    if (d[11:4] == 8'd0) r[7:4] = 4'hF;
    return r;
  endfunction

  function automatic logic [11:0] disp_now();
    return {bus.disp_huns, bus.disp_tens, bus.disp_ones};
  endfunction

  function automatic logic [11:0] res_now();
    return {bus.res_huns, bus.res_tens, bus.res_ones};
  endfunction

  // ---------------- drivers (enter and leave on a falling edge) ----------------
  task automatic key(input logic [3:0] d);
    bus.digit_in = d; bus.digit_stb = 1'b1;
    @(negedge clk);
    bus.digit_stb = 1'b0;
  endtask

  task automatic enter();
    bus.enter_stb = 1'b1;
    @(negedge clk);
    bus.enter_stb = 1'b0;
  endtask

  task automatic clr();
    bus.clr_stb = 1'b1;
    @(negedge clk);
    bus.clr_stb = 1'b0;
  endtask

  task automatic type_num(input int v);
    if (v >= 100) key(4'(v / 100));
    if (v >= 10)  key(4'((v / 10) % 10));
    key(4'(v % 10));
  endtask

  // Enters X and Y and stops on the falling edge after the result appears.
  task automatic go_done(input int x, input int y);
    type_num(x);
    enter();
    type_num(y);
    enter();
    @(negedge clk);
  endtask

  // Full transaction, checked against the head of the scoreboard queue.
  task automatic run_calc(input string tag, input int x, input int y, input bit pre_ready);
    logic [12:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_start_state"}, bus.state_o, S_LX);
    type_num(x);
    check({tag, "_disp_x"}, disp_now(), disp_of(to_bcd(x)));
    enter();
    check({tag, "_state_ly"}, bus.state_o, S_LY);
    check({tag, "_disp_y0"}, disp_now(), DISP_ZERO);
    type_num(y);
    check({tag, "_disp_y"}, disp_now(), disp_of(to_bcd(y)));
    bus.res_ready = pre_ready;
    enter();
    check({tag, "_calc"}, {bus.state_o, bus.res_valid}, {S_CALC, 1'b0});
    @(negedge clk);
    check({tag, "_valid"}, {bus.state_o, bus.res_valid}, {S_DONE, 1'b1});
    check({tag, "_res"}, {bus.res_neg, res_now()}, e);
    check({tag, "_disp"}, {bus.disp_neg, disp_now()}, {e[12], disp_of(e[11:0])});
    if (!pre_ready) begin
      repeat (2) @(negedge clk);
      check({tag, "_hold"}, {bus.res_valid, bus.res_neg, res_now()}, {1'b1, e});
      bus.res_ready = 1'b1;
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.res_valid, 1'b0);
`ifdef BCD_CALC_ACCUM_EN
    check({tag, "_accum_state"}, bus.state_o, S_LY);
    check({tag, "_accum_err"}, bus.err, e[12]);
    clr();
`else
    check({tag, "_back_lx"}, bus.state_o, S_LX);
    check({tag, "_disp_x0"}, disp_now(), DISP_ZERO);
`endif
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{x: 123, y: 45,  pre_ready: 1'b1, exp_mag: 78,  exp_neg: 1'b0};
    vecs[1] = '{x: 45,  y: 123, pre_ready: 1'b0, exp_mag: 78,  exp_neg: 1'b1};
    vecs[2] = '{x: 500, y: 500, pre_ready: 1'b1, exp_mag: 0,   exp_neg: 1'b0};
    vecs[3] = '{x: 999, y: 0,   pre_ready: 1'b0, exp_mag: 999, exp_neg: 1'b0};
    vecs[4] = '{x: 0,   y: 999, pre_ready: 1'b1, exp_mag: 999, exp_neg: 1'b1};
    vecs[5] = '{x: 7,   y: 3,   pre_ready: 1'b0, exp_mag: 4,   exp_neg: 1'b0};
    vecs[6] = '{x: 100, y: 1,   pre_ready: 1'b1, exp_mag: 99,  exp_neg: 1'b0};
    vecs[7] = '{x: 310, y: 309, pre_ready: 1'b0, exp_mag: 1,   exp_neg: 1'b0};

    bus.digit_in = '0; bus.digit_stb = 1'b0; bus.enter_stb = 1'b0;
    bus.clr_stb = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", bus.state_o, S_LX);
    check("rst_outs", {bus.res_valid, bus.err, bus.res_neg, res_now()}, 15'd0);
    check("rst_disp", {bus.disp_neg, disp_now()}, {1'b0, DISP_ZERO});
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", bus.state_o, S_LX);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].exp_neg, to_bcd(vecs[i].exp_mag)});
      run_calc($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].pre_ready);
    end

    // randomized against a plain-arithmetic model
    for (int i = 0; i < 20; i++) begin
      int x, y;
      x = int'($urandom_range(0, 999));
      y = int'($urandom_range(0, 999));
      exp_q.push_back({(y > x) ? 1'b1 : 1'b0, to_bcd((x >= y) ? x - y : y - x)});
      run_calc($sformatf("rnd%0d", i), x, y, 1'($urandom_range(0, 1)));
    end

    // entry errors: 4th digit and non-BCD code are ignored, err sticks until clr
    type_num(123);
    key(4'd4);
    check("err_4th_x", disp_now(), 12'h123);
    check("err_4th_flag", bus.err, 1'b1);
    key(4'hA);
    check("err_bad_digit_x", disp_now(), 12'h123);
    check("err_sticky", bus.err, 1'b1);
    clr();
    check("clr_err", {bus.err, bus.state_o}, {1'b0, S_LX});
    check("clr_x", disp_now(), DISP_ZERO);
    key(4'hC);
    check("bad_digit_fresh", {bus.err, disp_now()}, {1'b1, DISP_ZERO});
    clr();

    // clr beats a coincident digit
    key(4'd5);
    bus.digit_in = 4'd7; bus.digit_stb = 1'b1; bus.clr_stb = 1'b1;
    @(negedge clk);
    bus.digit_stb = 1'b0; bus.clr_stb = 1'b0;
    check("clr_digit_drop", {bus.state_o, disp_now()}, {S_LX, DISP_ZERO});

    // enter beats a coincident digit: the digit reaches neither X nor Y
    key(4'd1);
    bus.digit_in = 4'd9; bus.digit_stb = 1'b1; bus.enter_stb = 1'b1;
    @(negedge clk);
    bus.digit_stb = 1'b0; bus.enter_stb = 1'b0;
    check("enter_digit_drop", {bus.state_o, disp_now()}, {S_LY, DISP_ZERO});
    key(4'd2);
    enter();
    @(negedge clk);
    check("enter_digit_res", {bus.res_neg, res_now()}, {1'b1, 12'h001});
    clr();

    // backpressure in DONE with err already set; digit/enter ignored in DONE
    type_num(123);
    key(4'd4);
    enter();
    type_num(45);
    enter();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.digit_in = 4'd5;
      bus.digit_stb = (i == 3);
      bus.enter_stb = (i == 6);
      @(negedge clk);
      bus.digit_stb = 1'b0; bus.enter_stb = 1'b0;
      check($sformatf("bp_hold%0d", i),
            {bus.state_o, bus.res_valid, bus.res_neg, res_now(), bus.err},
            {S_DONE, 1'b1, 1'b0, 12'h078, 1'b1});
    end
    check("bp_disp", disp_now(), 12'hF78);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_done", {bus.state_o, bus.res_valid, bus.err, bus.res_neg, res_now()},
          {S_LX, 15'd0});
    check("rst_mid_disp", {bus.disp_neg, disp_now()}, {1'b0, DISP_ZERO});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clr in DONE discards an unaccepted result
    go_done(7, 30);
    check("pre_clr_done", {bus.res_valid, bus.disp_neg}, 2'b11);
    clr();
    check("clr_done", {bus.state_o, bus.res_valid, bus.res_neg, res_now()}, {S_LX, 14'd0});

`ifdef BCD_CALC_ACCUM_EN
    // chained subtraction: (100-30)-20
    bus.res_ready = 1'b1;
    go_done(100, 30);
    check("acc_first", {bus.res_neg, res_now()}, {1'b0, 12'h070});
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("acc_state", {bus.state_o, disp_now()}, {S_LY, DISP_ZERO});
    type_num(20);
    enter();
    @(negedge clk);
    check("acc_second", {bus.res_valid, bus.res_neg, res_now()}, {2'b10, 12'h050});
    clr();
    // negative result: X clears, err set, then 0-5
    bus.res_ready = 1'b1;
    go_done(10, 30);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("acc_neg_err", {bus.state_o, bus.err}, {S_LY, 1'b1});
    type_num(5);
    enter();
    @(negedge clk);
    check("acc_neg_x0", {bus.res_neg, res_now()}, {1'b1, 12'h005});
    clr();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
